// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
//   Shared definitions for the memory-access stage: datapath width,
//   access-size encodings, FSM state encoding and the byte-enable helper.
//   No ports (package).
package mem_stage_pkg;

   // Datapath width; mirrors INSTR_WIDTH of the core.
   localparam int INSTR_WIDTH = 32;

   // E_mem_size encodings.
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Access FSM states.
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } mem_state_e;

   // Byte enables for a little-endian 32-bit word; low address bits below
   // the access size are ignored (a half at offset 3 hits lanes 2-3).
   function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         SZ_BYTE: be = 4'b0001 << a;
         SZ_HALF: be = 4'b0011 << {a[1], 1'b0};
         SZ_WORD: be = 4'b1111;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// mem_load_align
//   Combinational load-data formatter: selects the addressed byte/half lane
//   of a raw little-endian read word and sign- or zero-extends it.
//   Ports:
//     rdata   in  DW  raw read word (lane 0 = bits 7:0)
//     addr_lo in  2   low address bits
//     size    in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//     sign    in  1   1 = sign-extend
//     data    out DW  aligned, extended load value
module mem_load_align
   import mem_stage_pkg::*;
#(
   parameter int DW = INSTR_WIDTH
)(
   input  logic [DW-1:0] rdata,
   input  logic [1:0]    addr_lo,
   input  logic [1:0]    size,
   input  logic          sign,
   output logic [DW-1:0] data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane selection: byte by full offset, half by offset bit 1.
   always_comb begin
      byte_s = 8'h00;
      case (addr_lo)
         2'd0:    byte_s = rdata[7:0];
         2'd1:    byte_s = rdata[15:8];
         2'd2:    byte_s = rdata[23:16];
         2'd3:    byte_s = rdata[31:24];
         default: byte_s = rdata[7:0];
      endcase
      if (addr_lo[1]) begin
         half_s = rdata[31:16];
      end else begin
         half_s = rdata[15:0];
      end
   end

   // Extension to full datapath width.
   always_comb begin
      data = rdata;
      case (size)
         SZ_BYTE: data = {{(DW-8){sign & byte_s[7]}}, byte_s};
         SZ_HALF: data = {{(DW-16){sign & half_s[15]}}, half_s};
         SZ_WORD: data = rdata;
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   Memory-access stage plus MEM/WB pipeline register. Issues load/store
//   requests over a req/ack handshake (any number of wait states), formats
//   store data / byte enables, aligns load data, and stalls upstream while an
//   access is outstanding. Stalled cycles enter a bubble into MEM/WB.
//   Optional feature macro: MEM_ALIGN_EXC_EN (misaligned half/word accesses
//   raise mem_exc / mem_badvaddr instead of accessing memory).
//   Ports:
//     clk, rst                  clock, async active-high reset
//     E_*                       EX/MEM slot inputs (held while mem_stall=1)
//     dmem_req/we/addr/be/wdata data memory request (combinational)
//     dmem_ack, dmem_rdata      data memory response
//     mem_stall                 hold upstream stages
//     W_MEM_*                   registered MEM/WB outputs
//     mem_exc, mem_badvaddr     (MEM_ALIGN_EXC_EN only) registered exception
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DW = INSTR_WIDTH,
   parameter int RW = 5
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          E_valid,
   input  logic [DW-1:0] E_alu_res,
   input  logic [DW-1:0] E_rt_data,
   input  logic          E_mem_rd,
   input  logic          E_mem_wr,
   input  logic [1:0]    E_mem_size,
   input  logic          E_mem_sign,
   input  logic          E_wb_sel,
   input  logic [RW-1:0] E_rd,
   input  logic          E_w_reg_ena,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [DW-1:0] dmem_addr,
   output logic [3:0]    dmem_be,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic          mem_stall,
`ifdef MEM_ALIGN_EXC_EN
   output logic          mem_exc,
   output logic [DW-1:0] mem_badvaddr,
`endif
   output logic [DW-1:0] W_MEM_alu_res,
   output logic [DW-1:0] W_MEM_mem_data,
   output logic          W_MEM_wb_sel,
   output logic [RW-1:0] W_MEM_rd,
   output logic          W_MEM_w_reg_ena
);

   mem_state_e    state_q, state_d;
   logic [1:0]    a_s;
   logic          mem_op_s;
   logic          misal_s;
   logic          acc_s;
   logic          done_s;
   logic [DW-1:0] load_data_s;

   logic [DW-1:0] alu_res_q, alu_res_d;
   logic [DW-1:0] mem_data_q, mem_data_d;
   logic          wb_sel_q, wb_sel_d;
   logic [RW-1:0] rd_q, rd_d;
   logic          w_reg_ena_q, w_reg_ena_d;

   assign a_s      = E_alu_res[1:0];
   assign mem_op_s = E_valid & (E_mem_rd | E_mem_wr);

`ifdef MEM_ALIGN_EXC_EN
   logic          exc_q, exc_d;
   logic [DW-1:0] badvaddr_q, badvaddr_d;

   // Misaligned half/word accesses are trapped instead of issued.
   always_comb begin
      misal_s = 1'b0;
      if (mem_op_s) begin
         misal_s = ((E_mem_size == SZ_HALF) & a_s[0]) |
                   ((E_mem_size == SZ_WORD) & (a_s != 2'b00));
      end else begin
         misal_s = 1'b0;
      end
   end
`else
   assign misal_s = 1'b0;
`endif

   assign acc_s  = mem_op_s & ~misal_s;
   // An ack only counts while a request is actually on the bus.
   assign done_s = dmem_req & dmem_ack;

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (acc_s & ~dmem_ack) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (dmem_ack) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs: request, direction and stall (all forced low in reset).
   always_comb begin
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      mem_stall = 1'b0;
      if (rst) begin
         dmem_req  = 1'b0;
         dmem_we   = 1'b0;
         mem_stall = 1'b0;
      end else begin
         case (state_q)
            S_IDLE:  dmem_req = acc_s;
            S_WAIT:  dmem_req = 1'b1;
            default: dmem_req = 1'b0;
         endcase
         dmem_we   = dmem_req & E_mem_wr;
         mem_stall = acc_s & ~dmem_ack;
      end
   end

   // Request address, byte enables and lane-replicated store data.
   always_comb begin
      dmem_addr  = {E_alu_res[DW-1:2], 2'b00};
      dmem_be    = calc_be(E_mem_size, a_s);
      dmem_wdata = E_rt_data;
      case (E_mem_size)
         SZ_BYTE: dmem_wdata = {4{E_rt_data[7:0]}};
         SZ_HALF: dmem_wdata = {2{E_rt_data[15:0]}};
         SZ_WORD: dmem_wdata = E_rt_data;
         default: dmem_wdata = E_rt_data;
      endcase
   end

   mem_load_align #(.DW(DW)) u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (a_s),
      .size    (E_mem_size),
      .sign    (E_mem_sign),
      .data    (load_data_s)
   );

   // MEM/WB next values: bubble on stall, capture otherwise.
   always_comb begin
      alu_res_d   = alu_res_q;
      mem_data_d  = mem_data_q;
      wb_sel_d    = wb_sel_q;
      rd_d        = rd_q;
      w_reg_ena_d = 1'b0;
      if (mem_stall) begin
         w_reg_ena_d = 1'b0;
      end else begin
         alu_res_d   = E_alu_res;
         wb_sel_d    = E_wb_sel;
         rd_d        = E_rd;
         w_reg_ena_d = E_w_reg_ena & E_valid & ~misal_s;
         if (done_s & E_mem_rd) begin
            mem_data_d = load_data_s;
         end else begin
            mem_data_d = mem_data_q;
         end
      end
   end

   // MEM/WB register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_res_q   <= {DW{1'b0}};
         mem_data_q  <= {DW{1'b0}};
         wb_sel_q    <= 1'b0;
         rd_q        <= {RW{1'b0}};
         w_reg_ena_q <= 1'b0;
      end else begin
         alu_res_q   <= alu_res_d;
         mem_data_q  <= mem_data_d;
         wb_sel_q    <= wb_sel_d;
         rd_q        <= rd_d;
         w_reg_ena_q <= w_reg_ena_d;
      end
   end

   assign W_MEM_alu_res   = alu_res_q;
   assign W_MEM_mem_data  = mem_data_q;
   assign W_MEM_wb_sel    = wb_sel_q;
   assign W_MEM_rd        = rd_q;
   assign W_MEM_w_reg_ena = w_reg_ena_q;

`ifdef MEM_ALIGN_EXC_EN
   // Exception next values; a trapped access never stalls.
   always_comb begin
      exc_d      = 1'b0;
      badvaddr_d = badvaddr_q;
      if (misal_s & ~mem_stall) begin
         exc_d      = 1'b1;
         badvaddr_d = E_alu_res;
      end else begin
         exc_d      = 1'b0;
         badvaddr_d = badvaddr_q;
      end
   end

   // Exception register, alongside MEM/WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exc_q      <= 1'b0;
         badvaddr_q <= {DW{1'b0}};
      end else begin
         exc_q      <= exc_d;
         badvaddr_q <= badvaddr_d;
      end
   end

   assign mem_exc      = exc_q;
   assign mem_badvaddr = badvaddr_q;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register; sits between the EX/MEM register and the write-back mux.
- Issues load/store requests to the data memory over a req/ack handshake, tolerating any number of wait states.
- Aligns and sign/zero-extends load data; generates byte enables for stores.
- Registers everything the write-back stage consumes (W_MEM_* outputs); stalls the pipeline while an access is outstanding.

Parameters:
- DW, 32, datapath width; equals INSTR_WIDTH from defines.v.
- RW, 5, register address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- E_valid  in  1  EX/MEM slot holds a real instruction
- E_alu_res  in  DW  ALU result / effective address
- E_rt_data  in  DW  store data
- E_mem_rd  in  1  load
- E_mem_wr  in  1  store (mutually exclusive with E_mem_rd)
- E_mem_size  in  2  00 byte, 01 half, 10 word
- E_mem_sign  in  1  sign-extend loads
- E_wb_sel  in  1  0 = ALU result, 1 = memory data
- E_rd  in  RW  destination register
- E_w_reg_ena  in  1  register write enable
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  DW  word-aligned address, low 2 bits 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  DW  lane-replicated store data
- dmem_ack  in  1  access complete; rdata valid this cycle for loads
- dmem_rdata  in  DW  raw read word
- mem_stall  out  1  hold upstream stages
- W_MEM_alu_res  out  DW
- W_MEM_mem_data  out  DW
- W_MEM_wb_sel  out  1
- W_MEM_rd  out  RW
- W_MEM_w_reg_ena  out  1

Behaviour:
- Reset: clk is the single clock; rst is asynchronous and active-high.
  - FSM goes to IDLE.
  - All W_MEM_* outputs reset to 0.
  - dmem_req, mem_stall and dmem_we are 0 while rst is high.
- Access: acc = E_valid & (E_mem_rd | E_mem_wr).
- FSM states IDLE and WAIT.
  - IDLE, acc=1: drive dmem_req combinationally. If dmem_ack=1 in the same cycle (zero wait), complete and stay in IDLE. Otherwise go to WAIT.
  - WAIT: hold dmem_req=1 with identical addr/be/wdata/we until dmem_ack=1, then complete and return to IDLE.
  - dmem_ack while dmem_req=0 is ignored.
- Stall: mem_stall = acc & ~dmem_ack.
  - Upstream holds all E_* inputs stable while mem_stall=1.
- MEM/WB register updates every cycle.
  - Completed access or non-memory valid instruction: capture E_alu_res, E_wb_sel, E_rd, and E_w_reg_ena & E_valid.
  - Stalled cycle: insert a bubble. W_MEM_w_reg_ena=0; other fields don't-care, implemented as hold.
  - Latency: 1 cycle after completion, i.e. after E_valid with no wait states.
- Byte enables from a = E_alu_res[1:0]:
  - byte: be = 0001 << a
  - half: be = 0011 << {a[1],0}
  - word: be = 1111
- Store data: byte replicated x4, half x2, word as-is.
- Load extract: select lane by a (half uses a[1]), extend to DW per E_mem_sign. The result is registered into W_MEM_mem_data on ack.
- Endianness: little-endian; lane 0 = bits 7:0.
- Misalignment (feature off): low address bits are ignored as above, so a half at a=3 accesses lanes 2-3.
- Reset mid-access: request dropped immediately; FSM returns to IDLE; a late ack after reset is ignored.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - Extra outputs mem_exc (1) and mem_badvaddr (DW), both registered alongside MEM/WB and reset to 0.
  - A half access with a[0]=1, or a word access with a!=0, issues no dmem_req and causes no stall.
  - On such an access: mem_exc=1, mem_badvaddr=E_alu_res, W_MEM_w_reg_ena=0 next cycle.
- Undefined: these ports are absent; low-bit masking applies.

Decomposition:
- Shared package/defines: DW via INSTR_WIDTH; size encodings (SZ_BYTE, SZ_HALF, SZ_WORD); FSM state encodings (S_IDLE, S_WAIT).
- One natural sub-module: mem_load_align, a combinational lane select plus sign/zero extension, reusable by a future cache.

Test Plan:
- Zero-wait word load: addr 0x100, ack same cycle, rdata 0xDEADBEEF, rd=5, wb_sel=1 -> no stall; next cycle W_MEM_mem_data=0xDEADBEEF, W_MEM_rd=5, W_MEM_w_reg_ena=1.
- Signed byte load: addr 0x103, rdata 0x80112233 -> W_MEM_mem_data=0xFFFFFF80; with sign=0 -> 0x00000080.
- Half store with 3 wait states: addr 0x202, data 0x0000ABCD -> dmem_be=1100, wdata=0xABCDABCD held stable 4 cycles; mem_stall=1 for 3 cycles; W_MEM_w_reg_ena=0 during the bubbles.
- ALU op (no mem), alu_res 0x12345678 -> no dmem_req; W_MEM_alu_res=0x12345678 one cycle later, wb_sel=0.
- rst asserted during WAIT -> dmem_req and W_MEM_w_reg_ena drop immediately; a subsequent ack has no effect.
- With MEM_ALIGN_EXC_EN: word load at 0x102 -> no dmem_req; mem_exc=1, mem_badvaddr=0x102, W_MEM_w_reg_ena=0.
